// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg -- shared types and constants for the sequential signed divider.
//
// Contents:
//   state_t           FSM states (IDLE, BUSY, FIX)
//   DIV_N             default operand width
//   DIV_BITS_PER_ITER quotient bits retired per BUSY cycle (1, or 2 with
//                     DIV_RADIX4_EN defined)
//   div_iters()       BUSY iteration count for a given operand width
//   DZ_QUOTIENT       quotient reported on divide-by-zero (all ones, i.e. -1)
//
// Build option: DIV_RADIX4_EN selects two quotient bits per cycle.
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DIV_N = 32;

`ifdef DIV_RADIX4_EN
    localparam int DIV_BITS_PER_ITER = 2;
`else
    localparam int DIV_BITS_PER_ITER = 1;
`endif

    function automatic int div_iters(input int n);
        return n / DIV_BITS_PER_ITER;
    endfunction

    localparam int DIV_ITERS = div_iters(DIV_N);

    localparam logic signed [DIV_N-1:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_signed_divider_if.sv
// -----------------------------------------------------------------------------
// seq_signed_divider_if -- start/done handshake and operand/result bus of the
// sequential signed divider.
//
// Signals:
//   start        request, sampled by the divider only while idle
//   dividend     signed dividend, captured when start is accepted
//   divisor      signed divisor, captured when start is accepted
//   busy         high from the accepting edge until done
//   done         one-cycle pulse, results valid
//   quotient     signed quotient, held until the next result
//   remainder    signed remainder (sign of dividend), held
//   div_by_zero  set with done when divisor was zero, held
//
// Modports: master (requester) drives operands/start, slave (divider) drives
// the results.
// -----------------------------------------------------------------------------
interface seq_signed_divider_if
    import div_pkg::*;
#(
    parameter int N = DIV_N
);
    logic                start;
    logic signed [N-1:0] dividend;
    logic signed [N-1:0] divisor;
    logic                busy;
    logic                done;
    logic signed [N-1:0] quotient;
    logic signed [N-1:0] remainder;
    logic                div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step -- one restoring-division step: shift the partial remainder left by
// one bringing in the next dividend bit, trial-subtract |divisor|, and keep the
// difference when it is non-negative.
//
// Ports:
//   rem_i  [N:0]    partial remainder in
//   bit_i           next dividend bit (MSB first)
//   dvs_i  [N-1:0]  divisor magnitude
//   rem_o  [N:0]    partial remainder out
//   q_o             quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int N = 32
) (
    input  logic [N:0]   rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] dvs_i,
    output logic [N:0]   rem_o,
    output logic         q_o
);
    logic [N:0]   shifted;
    logic [N+1:0] diff;

    assign shifted = {rem_i[N-1:0], bit_i};
    assign diff    = {1'b0, shifted} - {2'b00, dvs_i};

    // rem_i[N] set means the true shifted value exceeds 2^N, which is always
    // >= |divisor|; the kept difference is then exact modulo 2^(N+1).
    assign q_o   = rem_i[N] | ~diff[N+1];
    assign rem_o = q_o ? diff[N:0] : shifted;
endmodule

// File: rtl/seq_signed_divider.sv
// -----------------------------------------------------------------------------
// seq_signed_divider -- sequential signed N/N integer divider.
// Restoring division on operand magnitudes, one quotient bit per cycle
// (two with DIV_RADIX4_EN defined, N must then be even), followed by a single
// sign-correction cycle. Divide by zero skips straight to the fix cycle and
// reports quotient = -1, remainder = dividend, div_by_zero = 1.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (aborts any running operation)
//   bus  seq_signed_divider_if.slave: start/dividend/divisor in,
//        busy/done/quotient/remainder/div_by_zero out
//
// Build option: DIV_RADIX4_EN (two cascaded div_step stages per cycle).
// -----------------------------------------------------------------------------
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_signed_divider_if.slave  bus
);
    localparam int ITERS = div_iters(N);
    localparam int CNT_W = $clog2(ITERS + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N:0]          rem_q, rem_d;
    logic [N-1:0]        q_q, q_d;
    logic [N-1:0]        dvs_q, dvs_d;
    logic                sd_q, sd_d;
    logic                sq_q, sq_d;
    logic                dz_q, dz_d;
    logic                done_q, done_d;
    logic                dzo_q, dzo_d;
    logic signed [N-1:0] quot_q, quot_d;
    logic signed [N-1:0] rmd_q, rmd_d;

    logic [N-1:0]        abs_dvd, abs_dvs;
    logic [N:0]          rem_s1, rem_nx;
    logic                qb1;
    logic [N-1:0]        q_nx;

    // Magnitudes as unsigned N-bit values: |-2^(N-1)| = 2^(N-1) is representable.
    assign abs_dvd = bus.dividend[N-1] ? -bus.dividend : bus.dividend;
    assign abs_dvs = bus.divisor[N-1]  ? -bus.divisor  : bus.divisor;

    // The working quotient register doubles as the dividend shift register:
    // its MSB feeds the next step while quotient bits enter at the LSB.
    div_step #(.N(N)) u_step1 (
        .rem_i (rem_q),
        .bit_i (q_q[N-1]),
        .dvs_i (dvs_q),
        .rem_o (rem_s1),
        .q_o   (qb1)
    );

`ifdef DIV_RADIX4_EN
    logic [N:0] rem_s2;
    logic       qb2;

    div_step #(.N(N)) u_step2 (
        .rem_i (rem_s1),
        .bit_i (q_q[N-2]),
        .dvs_i (dvs_q),
        .rem_o (rem_s2),
        .q_o   (qb2)
    );

    assign rem_nx = rem_s2;
    assign q_nx   = {q_q[N-3:0], qb1, qb2};
`else
    assign rem_nx = rem_s1;
    assign q_nx   = {q_q[N-2:0], qb1};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        sd_d    = sd_q;
        sq_d    = sq_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        dzo_d   = dzo_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvs_d = abs_dvs;
                    sd_d  = bus.dividend[N-1];
                    sq_d  = bus.divisor[N-1];
                    cnt_d = '0;
                    if (bus.divisor == '0) begin
                        // Park |dividend| in the remainder so the fix cycle
                        // restores the original dividend with its sign.
                        rem_d   = {1'b0, abs_dvd};
                        q_d     = '0;
                        dz_d    = 1'b1;
                        state_d = FIX;
                    end else begin
                        rem_d   = '0;
                        q_d     = abs_dvd;
                        dz_d    = 1'b0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = rem_nx;
                q_d   = q_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz_q) begin
                    quot_d = N'(DZ_QUOTIENT);
                end else begin
                    quot_d = (sd_q ^ sq_q) ? -q_q : q_q;
                end
                rmd_d   = sd_q ? -rem_q[N-1:0] : rem_q[N-1:0];
                dzo_d   = dz_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            sd_q    <= 1'b0;
            sq_q    <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
            quot_q  <= '0;
            rmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            sd_q    <= sd_d;
            sq_q    <= sq_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dzo_q;
endmodule
